measurement_readout: RTL and testbench



---
 rtl/readout_pkg.sv | 20 ++
 rtl/readout_packet_shifter.sv | 36 +++
 rtl/measurement_readout.sv | 140 ++++++++++++++
 tb/tb_measurement_readout.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared types and packet-geometry helpers for the measurement readout block.
package readout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int HDR_BITS = 8;

  function automatic int bpw(input int counter_bits);
    return counter_bits / 8;
  endfunction

  function automatic int pkt_bytes(input int counter_bits);
    return 1 + 3 * bpw(counter_bits);
  endfunction

endpackage

// File: rtl/readout_packet_shifter.sv
// Holds one packet (header + counter snapshot) and presents it MSB byte first,
// advancing one byte per accepted transfer.
module readout_packet_shifter
  import readout_pkg::*;
#(
  parameter int DATA_BITS = 96
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [HDR_BITS-1:0]  i_header,
  input  logic [DATA_BITS-1:0] i_snapshot,
  output logic [7:0]           o_byte
);

  localparam int TOTAL_BITS = HDR_BITS + DATA_BITS;

  logic [TOTAL_BITS-1:0] r_shreg;

  // Packet register: parallel load on LOAD, shift left one byte per transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg <= {TOTAL_BITS{1'b0}};
    end else if (i_load) begin
      r_shreg <= {i_header, i_snapshot};
    end else if (i_shift) begin
      r_shreg <= {r_shreg[TOTAL_BITS-HDR_BITS-1:0], {HDR_BITS{1'b0}}};
    end else begin
      r_shreg <= r_shreg;
    end
  end

  assign o_byte = r_shreg[TOTAL_BITS-1 -: 8];

endmodule

// File: rtl/measurement_readout.sv
// Readout FSM: snapshots one pixel's TIME_HIGH/TIME_LOW/PERIOD per packet and
// streams the packets as bytes over a valid/ready interface.
module measurement_readout
  import readout_pkg::*;
#(
  parameter int PIXELS       = 128,
  parameter int COUNTER_BITS = 32,
  parameter int IDX_BITS     = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic                           i_scan_all,
  input  logic [IDX_BITS-1:0]            i_pixel_sel,
  input  logic [PIXELS*COUNTER_BITS-1:0] i_time_high,
  input  logic [PIXELS*COUNTER_BITS-1:0] i_time_low,
  input  logic [PIXELS*COUNTER_BITS-1:0] i_period,
  output logic [7:0]                     o_out_data,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic                           o_out_sop,
  output logic                           o_out_eop,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int PKT_BYTES = pkt_bytes(COUNTER_BITS);
  localparam int CNT_BITS  = $clog2(PKT_BYTES);
  localparam int SNAP_BITS = 3 * COUNTER_BITS;
  localparam logic [IDX_BITS-1:0] MAX_IDX  = IDX_BITS'(PIXELS - 1);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(PKT_BYTES - 1);

  state_t                r_state, w_state_nxt;
  logic [IDX_BITS-1:0]   r_idx, r_last, w_idx_nxt, w_last_nxt, w_sel_clamped;
  logic [CNT_BITS-1:0]   r_byte_cnt, w_cnt_nxt;
  logic                  r_valid, r_sop, r_eop, r_busy, r_done;
  logic                  w_done_nxt, w_load, w_xfer;
  logic [SNAP_BITS-1:0]  w_snapshot;
  logic [HDR_BITS-1:0]   w_header;

  assign w_xfer        = (r_state == SEND) && i_out_ready;
  assign w_sel_clamped = (int'(i_pixel_sel) >= PIXELS) ? MAX_IDX : i_pixel_sel;
  assign w_header      = HDR_BITS'(r_idx);
  assign w_snapshot    = {i_time_high[int'(r_idx)*COUNTER_BITS +: COUNTER_BITS],
                          i_time_low [int'(r_idx)*COUNTER_BITS +: COUNTER_BITS],
                          i_period   [int'(r_idx)*COUNTER_BITS +: COUNTER_BITS]};

  // Next-state logic; a start seen while done is still high belongs to the
  // frame that just ended and is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_byte_cnt;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !r_done) begin
          w_state_nxt = LOAD;
          if (i_scan_all) begin
            w_idx_nxt  = {IDX_BITS{1'b0}};
            w_last_nxt = MAX_IDX;
          end else begin
            w_idx_nxt  = w_sel_clamped;
            w_last_nxt = w_sel_clamped;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        w_load      = 1'b1;
        w_cnt_nxt   = {CNT_BITS{1'b0}};
        w_state_nxt = SEND;
      end
      SEND: begin
        if (!w_xfer) begin
          w_state_nxt = SEND;
        end else if (r_byte_cnt != LAST_CNT) begin
          w_cnt_nxt = r_byte_cnt + CNT_BITS'(1);
        end else if (r_idx < r_last) begin
          w_idx_nxt   = r_idx + IDX_BITS'(1);
          w_state_nxt = LOAD;
        end else begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered stream qualifiers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= {IDX_BITS{1'b0}};
      r_last     <= {IDX_BITS{1'b0}};
      r_byte_cnt <= {CNT_BITS{1'b0}};
      r_valid    <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_last     <= w_last_nxt;
      r_byte_cnt <= w_cnt_nxt;
      r_valid    <= (w_state_nxt == SEND);
      r_sop      <= (w_state_nxt == SEND) && (w_cnt_nxt == {CNT_BITS{1'b0}});
      r_eop      <= (w_state_nxt == SEND) && (w_cnt_nxt == LAST_CNT) &&
                    (w_idx_nxt == w_last_nxt);
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= w_done_nxt;
    end
  end

  readout_packet_shifter #(
    .DATA_BITS (SNAP_BITS)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_shift    (w_xfer),
    .i_header   (w_header),
    .i_snapshot (w_snapshot),
    .o_byte     (o_out_data)
  );

  assign o_out_valid = r_valid;
  assign o_out_sop   = r_sop;
  assign o_out_eop   = r_eop;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_measurement_readout.sv
// Scoreboard bench for measurement_readout: expected bytes are queued when a
// readout is launched and popped as the DUT transfers them.
module tb_measurement_readout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          i_start = 1'b0, i_scan_all = 1'b0, i_out_ready = 1'b0;
  logic [6:0]    i_pixel_sel = 7'd0;
  logic [4095:0] th = '0, tl = '0, per = '0;
  logic [7:0]    o_out_data;
  logic          o_out_valid, o_out_sop, o_out_eop, o_busy, o_done;

  // Second instance with a non-power-of-two pixel count to exercise clamping.
  logic          start2 = 1'b0, ready2 = 1'b1, scan2 = 1'b0;
  logic [6:0]    sel2 = 7'd0;
  logic [3071:0] th2 = '0, tl2 = '0, per2 = '0;
  logic [7:0]    data2;
  logic          valid2, sop2, eop2, busy2, done2;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];
  logic [7:0] exp2_q[$];

  measurement_readout #(.PIXELS(128), .COUNTER_BITS(32), .IDX_BITS(7)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_scan_all(i_scan_all),
    .i_pixel_sel(i_pixel_sel), .i_time_high(th), .i_time_low(tl), .i_period(per),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_sop(o_out_sop), .o_out_eop(o_out_eop), .o_busy(o_busy), .o_done(o_done)
  );

  measurement_readout #(.PIXELS(96), .COUNTER_BITS(32), .IDX_BITS(7)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .i_scan_all(scan2),
    .i_pixel_sel(sel2), .i_time_high(th2), .i_time_low(tl2), .i_period(per2),
    .o_out_data(data2), .o_out_valid(valid2), .i_out_ready(ready2),
    .o_out_sop(sop2), .o_out_eop(eop2), .o_busy(busy2), .o_done(done2)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_pixel(input int i, input bit is_last);
    logic [95:0] words;
    words = {th[i*32 +: 32], tl[i*32 +: 32], per[i*32 +: 32]};
    exp_q.push_back({1'b1, 1'b0, 8'(i)});
    for (int b = 0; b < 12; b++)
      exp_q.push_back({1'b0, (is_last && b == 11), words[95 - 8*b -: 8]});
  endtask

  task automatic start_read(input bit scan, input logic [6:0] sel);
    @(negedge clk);
    i_start = 1'b1; i_scan_all = scan; i_pixel_sel = sel;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Pops/compares transferred bytes; checks held bytes stay stable under stall.
  task automatic drain(input int budget, input bit rnd, input int change_after,
                       input int stop_after);
    int popped = 0;
    bit stalled = 1'b0;
    bit rdy;
    logic [9:0] held = '0, got, want;
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      got = {o_out_sop, o_out_eop, o_out_data};
      if (stalled) begin
        n_checks++;
        if (got !== held) begin
          n_errors++;
          $display("FAIL hold_stable: got %h required %h", got, held);
        end
      end
      if (popped == stop_after) break;
      n_checks++;
      if (o_done !== 1'b0) begin
        n_errors++;
        $display("FAIL early_done: done=%b required 0 with %0d bytes pending", o_done, exp_q.size());
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_out_ready = rdy;
      if (o_out_valid === 1'b1 && rdy) begin
        want = exp_q.pop_front();
        n_checks++;
        if (got !== want) begin
          n_errors++;
          $display("FAIL byte[%0d] {sop,eop,data}: got %h required %h", popped, got, want);
        end
        popped++;
        if (popped == change_after) th[5*32 +: 32] = 32'hDEADBEEF;
      end
      stalled = (o_out_valid === 1'b1) && !rdy;
      held = got;
    end
    if (popped != stop_after) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_errors++;
        $display("FAIL drain_timeout: %0d bytes left, required 0", exp_q.size());
      end
    end
  endtask

  task automatic check_done_pulse(input string name);
    @(negedge clk);
    n_checks++;
    if ({o_done, o_busy, o_out_valid} !== 3'b100) begin
      n_errors++;
      $display("FAIL %s_done: {done,busy,valid}=%b required 100", name, {o_done, o_busy, o_out_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({o_done, o_busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL %s_after_done: {done,busy}=%b required 00", name, {o_done, o_busy});
    end
  endtask

  task automatic set_pixel5(input logic [31:0] h);
    th[5*32 +: 32]  = h;
    tl[5*32 +: 32]  = 32'h55667788;
    per[5*32 +: 32] = 32'h99AABBCC;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_out_data, o_out_valid, o_out_sop, o_out_eop, o_busy, o_done} !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {o_out_data, o_out_valid, o_out_sop, o_out_eop, o_busy, o_done});
    end
    n_checks++;
    if ({data2, valid2, sop2, eop2, busy2, done2} !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_outputs2: got %h required 0", {data2, valid2, sop2, eop2, busy2, done2});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_pixel;
    set_pixel5(32'h11223344);
    push_pixel(5, 1'b1);
    start_read(1'b0, 7'd5);
    drain(60, 1'b0, -1, -1);
    check_done_pulse("single");
  endtask

  task automatic test_backpressure;
    set_pixel5(32'h11223344);
    push_pixel(5, 1'b1);
    start_read(1'b0, 7'd5);
    drain(600, 1'b1, -1, -1);
    check_done_pulse("backpressure");
    i_out_ready = 1'b1;
  endtask

  task automatic test_snapshot;
    set_pixel5(32'h11223344);
    push_pixel(5, 1'b1);
    start_read(1'b0, 7'd5);
    drain(60, 1'b0, 2, -1);
    check_done_pulse("snapshot");
    push_pixel(5, 1'b1);
    start_read(1'b0, 7'd5);
    drain(60, 1'b0, -1, -1);
    check_done_pulse("snapshot_new");
  endtask

  task automatic test_start_while_busy;
    th[3*32 +: 32] = 32'hA1B2C3D4;
    tl[3*32 +: 32] = 32'h0F1E2D3C;
    per[3*32 +: 32] = 32'h01020304;
    push_pixel(3, 1'b1);
    start_read(1'b0, 7'd3);
    i_start = 1'b1; i_pixel_sel = 7'd9;
    drain(60, 1'b0, -1, -1);
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_start_done: done=%b required 1", o_done);
    end
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({o_busy, o_out_valid} !== 2'b00) begin
        n_errors++;
        $display("FAIL busy_start_ignored: {busy,valid}=%b required 00", {o_busy, o_out_valid});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clamp;
    logic [7:0] got;
    th[127*32 +: 32] = 32'hCAFEF00D;
    push_pixel(127, 1'b1);
    start_read(1'b0, 7'd127);
    drain(60, 1'b0, -1, -1);
    check_done_pulse("max_pixel");
    for (int i = 0; i < 96; i++) th2[i*32 +: 32] = 32'hC0000000 | 32'(i);
    exp2_q.push_back(8'h5F);
    exp2_q.push_back(8'hC0);
    exp2_q.push_back(8'h00);
    exp2_q.push_back(8'h00);
    exp2_q.push_back(8'h5F);
    for (int b = 0; b < 8; b++) exp2_q.push_back(8'h00);
    @(negedge clk);
    start2 = 1'b1; sel2 = 7'd120;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 40 && exp2_q.size() > 0; c++) begin
      @(negedge clk);
      if (valid2 === 1'b1) begin
        got = exp2_q.pop_front();
        n_checks++;
        if (data2 !== got) begin
          n_errors++;
          $display("FAIL clamp_byte: got %h required %h", data2, got);
        end
      end
    end
    n_checks++;
    if (exp2_q.size() != 0) begin
      n_errors++;
      $display("FAIL clamp_timeout: %0d bytes left, required 0", exp2_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    set_pixel5(32'h11223344);
    push_pixel(5, 1'b1);
    start_read(1'b0, 7'd5);
    drain(60, 1'b0, -1, 7);
    n_checks++;
    if ({o_out_valid, o_out_data} !== {1'b1, 8'h77}) begin
      n_errors++;
      $display("FAIL mid_byte7: {valid,data}=%h required 177", {o_out_valid, o_out_data});
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_out_valid, o_busy, o_done} !== 3'b000) begin
      n_errors++;
      $display("FAIL mid_reset: {valid,busy,done}=%b required 000", {o_out_valid, o_busy, o_done});
    end
    rst_n = 1'b1;
    exp_q.delete();
    push_pixel(5, 1'b1);
    start_read(1'b0, 7'd5);
    drain(60, 1'b0, -1, -1);
    check_done_pulse("after_reset");
  endtask

  task automatic test_full_scan;
    int cyc = 0, bubbles = 0, popped = 0;
    bit got_done = 1'b0;
    logic [9:0] got, want;
    tl = '0; per = '0;
    for (int i = 0; i < 128; i++) th[i*32 +: 32] = 32'(i);
    for (int i = 0; i < 128; i++) push_pixel(i, i == 127);
    i_out_ready = 1'b1;
    start_read(1'b1, 7'd0);
    while (!got_done && cyc < 2500) begin
      if (o_done === 1'b1) begin
        got_done = 1'b1;
      end else begin
        if (o_out_valid === 1'b1) begin
          got = {o_out_sop, o_out_eop, o_out_data};
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
          n_checks++;
          if (got !== want) begin
            n_errors++;
            $display("FAIL scan_byte[%0d]: got %h required %h", popped, got, want);
          end
          popped++;
        end else if (o_busy === 1'b1) begin
          bubbles++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    n_checks++;
    if (cyc != 1792) begin
      n_errors++;
      $display("FAIL scan_latency: done at cycle %0d required 1792", cyc);
    end
    n_checks++;
    if (bubbles != 128) begin
      n_errors++;
      $display("FAIL scan_bubbles: got %0d required 128", bubbles);
    end
    n_checks++;
    if (popped != 1664 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scan_count: got %0d bytes, %0d pending, required 1664, 0", popped, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_backpressure();
    test_snapshot();
    test_start_while_busy();
    test_clamp();
    test_reset_mid_frame();
    test_full_scan();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
